i2c_req_arbiter: RTL

Shares the single APB I2C master among NUM_REQ on-chip requesters. Each requester posts a one-byte read or write request. The block grants requesters round-robin and launches the transaction on the I2C master through its APB slave port. It then polls the master's status/RX register until completion or timeout and returns the result to the granted requester. It sits between the requester clients and the APB slave port of the I2C master, and is the only APB master of that peripheral.

---
 rtl/i2c_req_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one APB I2C master among NUM_REQ requesters:
// launches a one-byte transfer, polls status until done or timeout, returns the result.
module i2c_req_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int APB_ADDR_WIDTH = 7,
   parameter int LAUNCH_HOLDOFF = 16,
   parameter int POLL_GAP       = 8,
   parameter int TIMEOUT        = 4096
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [8*NUM_REQ-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [7:0]                rsp_rdata,
   output logic                      rsp_err,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);
   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int WAIT_MAX = (LAUNCH_HOLDOFF > POLL_GAP) ? LAUNCH_HOLDOFF : POLL_GAP;
   localparam int WAIT_W = $clog2(WAIT_MAX + 1);
   localparam int TMO_W  = $clog2(TIMEOUT + 1);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_LAUNCH = APB_ADDR_WIDTH'(4);
   localparam logic [APB_ADDR_WIDTH-1:0] ADDR_STATUS = '0;

   typedef enum logic [2:0] {
      S_IDLE, S_L_SETUP, S_L_ACCESS, S_HOLDOFF, S_P_SETUP, S_P_ACCESS, S_GAP, S_RESPOND
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [PTR_W-1:0]          r_rr_ptr;
   logic [PTR_W-1:0]          r_gnt;
   logic                      r_write;
   logic [WAIT_W-1:0]         r_wait;
   logic [TMO_W-1:0]          r_tmo;
   logic [NUM_REQ-1:0]        r_req_ready;
   logic [NUM_REQ-1:0]        r_rsp_valid;
   logic [7:0]                r_rsp_rdata;
   logic                      r_rsp_err;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [31:0]               r_pwdata;
   logic                      r_pwrite;
   logic                      r_psel;
   logic                      r_penable;

   logic [PTR_W-1:0]          w_gnt;
   logic                      w_found;
   logic                      w_tmo_hit;
   logic                      w_done_err;
   logic [7:0]                w_done_data;
   logic                      w_unused_prdata;

   assign w_unused_prdata = ^{PRDATA[31:16], PRDATA[14:8]};
   assign w_tmo_hit       = (r_tmo >= TMO_W'(TIMEOUT));

   // First asserted request strictly after the last grantee, wrapping.
   always_comb begin
      w_gnt   = r_rr_ptr;
      w_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_gnt   = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      w_done_err  = 1'b0;
      w_done_data = 8'h00;
      case (r_state)
         S_IDLE:     if (w_found) w_next = S_L_SETUP;
         S_L_SETUP:  w_next = S_L_ACCESS;
         S_L_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  w_next     = S_RESPOND;
                  w_done_err = 1'b1;
               end else begin
                  w_next = S_HOLDOFF;
               end
            end
         end
         S_HOLDOFF: begin
            if (w_tmo_hit) begin
               w_next     = S_RESPOND;
               w_done_err = 1'b1;
            end else if (r_wait == WAIT_W'(LAUNCH_HOLDOFF - 1)) begin
               w_next = S_P_SETUP;
            end
         end
         // A poll already in setup is always carried through its access phase
         // so the APB bus never sees an abandoned transfer.
         S_P_SETUP:  w_next = S_P_ACCESS;
         S_P_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  w_next     = S_RESPOND;
                  w_done_err = 1'b1;
               end else if (PRDATA[15]) begin
                  w_next      = S_RESPOND;
                  w_done_data = r_write ? 8'h00 : PRDATA[7:0];
               end else begin
                  w_next = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (w_tmo_hit) begin
               w_next     = S_RESPOND;
               w_done_err = 1'b1;
            end else if (r_wait == WAIT_W'(POLL_GAP - 1)) begin
               w_next = S_P_SETUP;
            end
         end
         S_RESPOND:  w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
         r_gnt       <= '0;
         r_write     <= 1'b0;
         r_wait      <= '0;
         r_tmo       <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= 8'h00;
         r_rsp_err   <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= 32'h0;
         r_pwrite    <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_psel      <= (w_next == S_L_SETUP) || (w_next == S_L_ACCESS) ||
                        (w_next == S_P_SETUP) || (w_next == S_P_ACCESS);
         r_penable   <= (w_next == S_L_ACCESS) || (w_next == S_P_ACCESS);
         r_req_ready <= '0;
         r_rsp_valid <= '0;

         if (r_state == S_IDLE && w_found) begin
            r_gnt       <= w_gnt;
            r_rr_ptr    <= w_gnt;
            r_write     <= req_write[w_gnt];
            r_req_ready <= NUM_REQ'(1) << w_gnt;
            r_paddr     <= ADDR_LAUNCH;
            r_pwrite    <= req_write[w_gnt];
            r_pwdata    <= {24'h0, req_wdata[{w_gnt, 3'b000} +: 8]};
         end

         if (w_next == S_P_SETUP && r_state != S_P_SETUP) begin
            r_paddr  <= ADDR_STATUS;
            r_pwrite <= 1'b0;
         end

         if (w_next == S_RESPOND && r_state != S_RESPOND) begin
            r_rsp_valid <= NUM_REQ'(1) << r_gnt;
            r_rsp_err   <= w_done_err;
            r_rsp_rdata <= w_done_data;
         end

         if (w_next != r_state) begin
            r_wait <= '0;
         end else if (r_state == S_HOLDOFF || r_state == S_GAP) begin
            r_wait <= r_wait + 1'b1;
         end

         // Timeout measured from launch completion; saturates once reached.
         if (r_state == S_L_ACCESS) begin
            r_tmo <= '0;
         end else if ((r_state == S_HOLDOFF || r_state == S_P_SETUP ||
                       r_state == S_P_ACCESS || r_state == S_GAP) && !w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PWRITE    = r_pwrite;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;

endmodule
